// File: rtl/axi_pkg.sv
// rtl/axi_pkg.sv - shared AXI response codes and read-data router state encoding
package axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } router_state_e;

endpackage

// File: rtl/axi_rr_arbiter.sv
// rtl/axi_rr_arbiter.sv - combinational round-robin arbiter with pointer input
module axi_rr_arbiter #(
  parameter int N  = 5,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_grant_oh,
  output logic [IW-1:0] o_grant_idx,
  output logic          o_any
);

  logic          w_hi_found;
  logic [IW-1:0] w_hi_idx;
  logic [IW-1:0] w_lo_idx;

  // Lowest requester at or above the pointer wins; otherwise wrap to the lowest requester overall.
  always_comb begin
    w_hi_found = 1'b0;
    w_hi_idx   = '0;
    w_lo_idx   = '0;
    for (int j = N - 1; j >= 0; j--) begin
      if (i_req[j] && (IW'(j) >= i_ptr)) begin
        w_hi_found = 1'b1;
        w_hi_idx   = IW'(j);
      end
      if (i_req[j]) begin
        w_lo_idx = IW'(j);
      end
    end
    o_any       = |i_req;
    o_grant_idx = w_hi_found ? w_hi_idx : w_lo_idx;
    o_grant_oh  = '0;
    for (int j = 0; j < N; j++) begin
      o_grant_oh[j] = o_any && (IW'(j) == o_grant_idx);
    end
  end

endmodule

// File: rtl/axi_rdata_router.sv
// rtl/axi_rdata_router.sv - AXI R-channel router from slaves plus a default DECERR slave to masters
module axi_rdata_router
  import axi_pkg::*;
#(
  parameter int  NUM_M     = 3,
  parameter int  NUM_S     = 4,
  parameter int  ID_BITS   = 4,
  parameter int  DATA_BITS = 32,
  localparam int MB        = $clog2(NUM_M),
  localparam int MBW       = (MB > 0) ? MB : 1,
  localparam int SID       = ID_BITS + MB
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_S*SID-1:0]       s_rid,
  input  logic [NUM_S*DATA_BITS-1:0] s_rdata,
  input  logic [NUM_S*2-1:0]         s_rresp,
  input  logic [NUM_S-1:0]           s_rlast,
  input  logic [NUM_S-1:0]           s_rvalid,
  output logic [NUM_S-1:0]           s_rready,
  output logic [NUM_M*ID_BITS-1:0]   m_rid,
  output logic [NUM_M*DATA_BITS-1:0] m_rdata,
  output logic [NUM_M*2-1:0]         m_rresp,
  output logic [NUM_M-1:0]           m_rlast,
  output logic [NUM_M-1:0]           m_rvalid,
  input  logic [NUM_M-1:0]           m_rready,
  input  logic                       err_req_valid,
  output logic                       err_req_ready,
  input  logic [MBW-1:0]             err_req_master,
  input  logic [ID_BITS-1:0]         err_req_id,
  input  logic [7:0]                 err_req_len,
  output logic [NUM_S:0]             finish,
  output logic                       route_err
);

  localparam int NUM_SRC = NUM_S + 1;
  localparam int SW      = $clog2(NUM_SRC);

  // Source view: real slaves first, default slave at index NUM_S
  logic [NUM_SRC-1:0]   w_src_valid;
  logic [NUM_SRC-1:0]   w_src_last;
  logic [SID-1:0]       w_src_id   [NUM_SRC];
  logic [DATA_BITS-1:0] w_src_data [NUM_SRC];
  logic [1:0]           w_src_resp [NUM_SRC];

  // Default slave context
  logic                 r_err_pending;
  logic [MBW-1:0]       r_err_master;
  logic [ID_BITS-1:0]   r_err_id;
  logic [7:0]           r_err_cnt;
  logic                 w_err_acc;
  logic                 w_def_hs;

  // Arbitration and FSM
  router_state_e        r_state;
  router_state_e        w_state_nxt;
  logic [SW-1:0]        r_grant;
  logic [SW-1:0]        w_grant_nxt;
  logic [SW-1:0]        r_rr_ptr;
  logic [SW-1:0]        w_rr_ptr_nxt;
  logic [SW-1:0]        w_arb_idx;
  logic [NUM_SRC-1:0]   w_arb_oh;
  logic                 w_arb_any;
  logic [SW-1:0]        w_grant;
  logic [NUM_SRC-1:0]   w_grant_oh;

  // Granted beat
  logic                 w_gvalid;
  logic [SID-1:0]       w_gid;
  logic [DATA_BITS-1:0] w_gdata;
  logic [1:0]           w_gresp;
  logic                 w_glast;
  logic [SID-1:0]       w_target;
  logic                 w_tgt_ok;
  logic                 w_tgt_rdy;
  logic                 w_hs;
  logic                 w_last_hs;

  function automatic logic [SW-1:0] f_next_src(input logic [SW-1:0] g);
    if (g == SW'(NUM_SRC - 1)) begin
      f_next_src = '0;
    end else begin
      f_next_src = g + SW'(1);
    end
  endfunction

  for (genvar s = 0; s < NUM_S; s++) begin : g_src
    assign w_src_valid[s] = s_rvalid[s];
    assign w_src_last[s]  = s_rlast[s];
    assign w_src_id[s]    = s_rid[s*SID +: SID];
    assign w_src_data[s]  = s_rdata[s*DATA_BITS +: DATA_BITS];
    assign w_src_resp[s]  = s_rresp[s*2 +: 2];
  end

  // The default slave answers a decode error with zero data and DECERR, rlast on the final count.
  assign w_src_valid[NUM_S] = r_err_pending;
  assign w_src_last[NUM_S]  = (r_err_cnt == 8'd0);
  assign w_src_id[NUM_S]    = SID'({r_err_master, r_err_id});
  assign w_src_data[NUM_S]  = '0;
  assign w_src_resp[NUM_S]  = RESP_DECERR;

  axi_rr_arbiter #(
    .N  (NUM_SRC),
    .IW (SW)
  ) u_arb (
    .i_req       (w_src_valid),
    .i_ptr       (r_rr_ptr),
    .o_grant_oh  (w_arb_oh),
    .o_grant_idx (w_arb_idx),
    .o_any       (w_arb_any)
  );

  // In IDLE the arbiter picks this cycle; in LOCK the registered grant holds the burst.
  assign w_grant    = (r_state == ST_IDLE) ? w_arb_idx : r_grant;
  assign w_grant_oh = (r_state == ST_IDLE) ? w_arb_oh : (NUM_SRC'(1) << r_grant);
  assign w_gvalid   = rst & ((r_state == ST_IDLE) ? w_arb_any : w_src_valid[r_grant]);
  assign w_gid      = w_src_id[w_grant];
  assign w_gdata    = w_src_data[w_grant];
  assign w_gresp    = w_src_resp[w_grant];
  assign w_glast    = w_src_last[w_grant];
  assign w_target   = w_gid >> ID_BITS;
  assign w_tgt_ok   = (w_target < SID'(NUM_M));

  // Ready of the targeted master; unmapped targets are handled by the sink path below.
  always_comb begin
    w_tgt_rdy = 1'b0;
    for (int m = 0; m < NUM_M; m++) begin
      if (w_target == SID'(m)) begin
        w_tgt_rdy = m_rready[m];
      end
    end
  end

  // Beats aimed at a nonexistent master are sunk so the slave burst can still complete.
  assign w_hs      = w_gvalid & (w_tgt_ok ? w_tgt_rdy : 1'b1);
  assign w_last_hs = w_hs & w_glast;
  assign s_rready  = w_hs ? w_grant_oh[NUM_S-1:0] : '0;
  assign finish    = w_last_hs ? w_grant_oh : '0;

  // Only the targeted master sees the granted beat; everything else is driven to zero.
  always_comb begin
    m_rvalid = '0;
    m_rid    = '0;
    m_rdata  = '0;
    m_rresp  = '0;
    m_rlast  = '0;
    for (int m = 0; m < NUM_M; m++) begin
      if (w_gvalid && w_tgt_ok && (w_target == SID'(m))) begin
        m_rvalid[m]                          = 1'b1;
        m_rid[m*ID_BITS +: ID_BITS]          = w_gid[ID_BITS-1:0];
        m_rdata[m*DATA_BITS +: DATA_BITS]    = w_gdata;
        m_rresp[m*2 +: 2]                    = w_gresp;
        m_rlast[m]                           = w_glast;
      end
    end
  end

  // Next-state logic: single-beat bursts stay in IDLE, longer ones lock the grant until rlast.
  always_comb begin
    w_state_nxt  = r_state;
    w_grant_nxt  = r_grant;
    w_rr_ptr_nxt = r_rr_ptr;
    case (r_state)
      ST_IDLE: begin
        if (w_gvalid) begin
          if (w_last_hs) begin
            w_rr_ptr_nxt = f_next_src(w_grant);
          end else begin
            w_state_nxt = ST_LOCK;
            w_grant_nxt = w_grant;
          end
        end
      end
      ST_LOCK: begin
        if (w_last_hs) begin
          w_state_nxt  = ST_IDLE;
          w_rr_ptr_nxt = f_next_src(r_grant);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // FSM state, locked grant and round-robin pointer registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ST_IDLE;
      r_grant  <= '0;
      r_rr_ptr <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_grant  <= w_grant_nxt;
      r_rr_ptr <= w_rr_ptr_nxt;
    end
  end

  // A new error request is only taken when no DECERR burst is outstanding.
  assign err_req_ready = rst & ~r_err_pending;
  assign w_err_acc     = err_req_valid & err_req_ready;
  assign w_def_hs      = w_hs & (w_grant == SW'(NUM_S));

  // Default-slave request capture and beat countdown.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err_pending <= 1'b0;
      r_err_master  <= '0;
      r_err_id      <= '0;
      r_err_cnt     <= 8'd0;
    end else if (w_err_acc) begin
      r_err_pending <= 1'b1;
      r_err_master  <= err_req_master;
      r_err_id      <= err_req_id;
      r_err_cnt     <= err_req_len;
    end else if (w_def_hs) begin
      if (r_err_cnt == 8'd0) begin
        r_err_pending <= 1'b0;
      end else begin
        r_err_cnt <= r_err_cnt - 8'd1;
      end
    end
  end

  // Sticky flag for any beat whose ID names a master that does not exist.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      route_err <= 1'b0;
    end else if (w_hs && !w_tgt_ok) begin
      route_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_axi_rdata_router.sv
// tb/tb_axi_rdata_router.sv - scoreboard bench for axi_rdata_router
module tb_axi_rdata_router;

  localparam int NM = 3;
  localparam int NS = 4;
  localparam int IDB = 4;
  localparam int SIDW = 6;
  localparam int DW = 32;

  logic              clk;
  logic              rst;
  logic [NS*SIDW-1:0] s_rid;
  logic [NS*DW-1:0]  s_rdata;
  logic [NS*2-1:0]   s_rresp;
  logic [NS-1:0]     s_rlast;
  logic [NS-1:0]     s_rvalid;
  logic [NS-1:0]     s_rready;
  logic [NM*IDB-1:0] m_rid;
  logic [NM*DW-1:0]  m_rdata;
  logic [NM*2-1:0]   m_rresp;
  logic [NM-1:0]     m_rlast;
  logic [NM-1:0]     m_rvalid;
  logic [NM-1:0]     m_rready;
  logic              err_req_valid;
  logic              err_req_ready;
  logic [1:0]        err_req_master;
  logic [IDB-1:0]    err_req_id;
  logic [7:0]        err_req_len;
  logic [NS:0]       finish;
  logic              route_err;

  typedef struct packed {
    logic [1:0]  m;
    logic [3:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
    logic [2:0]  src;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  axi_rdata_router #(
    .NUM_M(NM), .NUM_S(NS), .ID_BITS(IDB), .DATA_BITS(DW)
  ) dut (
    .clk(clk), .rst(rst),
    .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
    .s_rvalid(s_rvalid), .s_rready(s_rready),
    .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
    .m_rvalid(m_rvalid), .m_rready(m_rready),
    .err_req_valid(err_req_valid), .err_req_ready(err_req_ready),
    .err_req_master(err_req_master), .err_req_id(err_req_id), .err_req_len(err_req_len),
    .finish(finish), .route_err(route_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout act=running req=finished");
    $fatal(1, "global timeout");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s act=0x%0h req=0x%0h", name, act, req);
    end
  endtask

  task automatic push(input int m, input logic [3:0] id, input logic [31:0] data,
                      input logic [1:0] resp, input logic last, input int src);
    exp_t e;
    e.m = 2'(m); e.id = id; e.data = data; e.resp = resp; e.last = last; e.src = 3'(src);
    exp_q.push_back(e);
  endtask

  // Monitor: every accepted master beat is popped from the scoreboard and compared.
  always @(negedge clk) begin
    int   nv;
    exp_t e;
    nv = 0;
    for (int m = 0; m < NM; m++) if (m_rvalid[m]) nv++;
    chk("at_most_one_mvalid", 64'(nv <= 1), 64'd1);
    for (int m = 0; m < NM; m++) begin
      if (m_rvalid[m] && m_rready[m]) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat_master", 64'(m), 64'hFF);
        end else begin
          e = exp_q.pop_front();
          chk("beat_master", 64'(m), 64'(e.m));
          chk("beat_id",   64'(m_rid[m*IDB +: IDB]), 64'(e.id));
          chk("beat_data", 64'(m_rdata[m*DW +: DW]), 64'(e.data));
          chk("beat_resp", 64'(m_rresp[m*2 +: 2]), 64'(e.resp));
          chk("beat_last", 64'(m_rlast[m]), 64'(e.last));
          chk("beat_finish", 64'(finish), e.last ? 64'(5'b00001 << e.src) : 64'd0);
        end
      end
    end
  end

  // Present an n-beat burst on slave s; call and return just after a rising edge.
  task automatic slave_burst(input int s, input logic [5:0] id, input int n, input logic [31:0] base);
    bit hs;
    int k;
    for (int b = 0; b < n; b++) begin
      s_rvalid[s] = 1'b1;
      s_rid[s*SIDW +: SIDW] = id;
      s_rdata[s*DW +: DW] = base + 32'(b);
      s_rresp[s*2 +: 2] = 2'b00;
      s_rlast[s] = (b == n - 1);
      hs = 1'b0;
      k = 0;
      while (!hs && k < 200) begin
        @(negedge clk);
        hs = s_rready[s];
        @(posedge clk); #1;
        k++;
      end
      if (!hs) chk("slave_hs_timeout", 64'd0, 64'd1);
    end
    s_rvalid[s] = 1'b0;
    s_rlast[s] = 1'b0;
  endtask

  task automatic wait_empty(input string name);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 300) begin
      @(posedge clk); #1;
      k++;
    end
    chk(name, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    rst = 1'b0;
    s_rid = '0; s_rdata = '0; s_rresp = '0; s_rlast = '0; s_rvalid = '0;
    m_rready = 3'b111;
    err_req_valid = 1'b0; err_req_master = '0; err_req_id = '0; err_req_len = '0;
    s_rvalid[1] = 1'b1;
    s_rid[SIDW +: SIDW] = 6'b01_0011;

    // Reset: outputs held low even with a slave presenting a beat
    repeat (3) @(negedge clk);
    chk("rst_mvalid", 64'(m_rvalid), 64'd0);
    chk("rst_sready", 64'(s_rready), 64'd0);
    chk("rst_finish", 64'(finish), 64'd0);
    chk("rst_err_ready", 64'(err_req_ready), 64'd0);
    chk("rst_route_err", 64'(route_err), 64'd0);
    @(posedge clk); #1;
    s_rvalid = '0;
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_err_ready", 64'(err_req_ready), 64'd1);
    @(posedge clk); #1;

    // Slaves 0 and 2 both to master 2, rr_ptr 0: slave0 burst then slave2, no interleave
    for (int b = 0; b < 4; b++) push(2, 4'h1, 32'h100 + 32'(b), 2'b00, b == 3, 0);
    for (int b = 0; b < 4; b++) push(2, 4'h2, 32'h200 + 32'(b), 2'b00, b == 3, 2);
    fork
      slave_burst(0, 6'b10_0001, 4, 32'h100);
      slave_burst(2, 6'b10_0010, 4, 32'h200);
    join
    wait_empty("rr_bursts_drained");

    // Single beat from slave1 to master1, routed same cycle
    push(1, 4'h3, 32'h0000_00A0, 2'b00, 1'b1, 1);
    s_rvalid[1] = 1'b1;
    s_rid[SIDW +: SIDW] = 6'b01_0011;
    s_rdata[DW +: DW] = 32'h0000_00A0;
    s_rlast[1] = 1'b1;
    @(negedge clk);
    chk("single_mvalid", 64'(m_rvalid), 64'b010);
    chk("single_mrid1", 64'(m_rid[IDB +: IDB]), 64'h3);
    chk("single_finish", 64'(finish), 64'b00010);
    chk("single_sready", 64'(s_rready), 64'b0010);
    @(posedge clk); #1;
    s_rvalid[1] = 1'b0;
    s_rlast[1] = 1'b0;
    wait_empty("single_drained");

    // Decode-error burst: master 0, id 5, len 3 -> four DECERR beats
    for (int b = 0; b < 4; b++) push(0, 4'h5, 32'h0, 2'b11, b == 3, 4);
    err_req_valid = 1'b1;
    err_req_master = 2'd0;
    err_req_id = 4'h5;
    err_req_len = 8'd3;
    @(negedge clk);
    chk("err_ready_before", 64'(err_req_ready), 64'd1);
    @(posedge clk); #1;
    err_req_valid = 1'b0;
    @(negedge clk);
    chk("err_ready_pending", 64'(err_req_ready), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("err_ready_pending_mid", 64'(err_req_ready), 64'd0);
    wait_empty("err_burst_drained");
    @(negedge clk);
    chk("err_ready_after", 64'(err_req_ready), 64'd1);
    @(posedge clk); #1;

    // Master 0 ready toggling during a locked burst from slave3
    for (int b = 0; b < 4; b++) push(0, 4'h7, 32'h300 + 32'(b), 2'b00, b == 3, 3);
    fork
      slave_burst(3, 6'b00_0111, 4, 32'h300);
      begin
        for (int c = 0; c < 12; c++) begin
          m_rready[0] = (c % 2 == 1);
          @(negedge clk);
          if (s_rvalid[3]) chk("sready_tracks_mready", 64'(s_rready[3]), 64'(m_rready[0]));
          @(posedge clk); #1;
        end
        m_rready[0] = 1'b1;
      end
    join
    wait_empty("toggle_drained");
    chk("route_err_clean", 64'(route_err), 64'd0);

    // Slave0 beats naming master 3: sunk, no master valid, route_err sticky
    s_rvalid[0] = 1'b1;
    s_rid[0 +: SIDW] = 6'b11_1001;
    s_rdata[0 +: DW] = 32'hDEAD_0000;
    s_rlast[0] = 1'b0;
    @(negedge clk);
    chk("sink_mvalid_b0", 64'(m_rvalid), 64'd0);
    chk("sink_sready_b0", 64'(s_rready[0]), 64'd1);
    @(posedge clk); #1;
    s_rdata[0 +: DW] = 32'hDEAD_0001;
    s_rlast[0] = 1'b1;
    @(negedge clk);
    chk("sink_mvalid_b1", 64'(m_rvalid), 64'd0);
    chk("sink_sready_b1", 64'(s_rready[0]), 64'd1);
    chk("sink_finish", 64'(finish), 64'b00001);
    @(posedge clk); #1;
    s_rvalid[0] = 1'b0;
    s_rlast[0] = 1'b0;
    @(negedge clk);
    chk("route_err_set", 64'(route_err), 64'd1);
    @(posedge clk); #1;

    // Reset at beat 2 of a 4-beat slave1 burst, then a fresh request
    push(1, 4'h4, 32'h400, 2'b00, 1'b0, 1);
    push(1, 4'h4, 32'h401, 2'b00, 1'b0, 1);
    s_rvalid[1] = 1'b1;
    s_rid[SIDW +: SIDW] = 6'b01_0100;
    s_rlast[1] = 1'b0;
    for (int b = 0; b < 2; b++) begin
      s_rdata[DW +: DW] = 32'h400 + 32'(b);
      @(negedge clk);
      chk("abort_sready", 64'(s_rready[1]), 64'd1);
      @(posedge clk); #1;
    end
    s_rdata[DW +: DW] = 32'h402;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_mvalid", 64'(m_rvalid), 64'd0);
    chk("abort_sready_rst", 64'(s_rready), 64'd0);
    chk("abort_finish", 64'(finish), 64'd0);
    chk("abort_err_ready", 64'(err_req_ready), 64'd0);
    chk("abort_q_empty", 64'(exp_q.size()), 64'd0);
    s_rvalid[1] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("abort_route_err_cleared", 64'(route_err), 64'd0);
    chk("abort_err_ready_after", 64'(err_req_ready), 64'd1);
    @(posedge clk); #1;
    push(0, 4'hC, 32'h500, 2'b00, 1'b1, 2);
    slave_burst(2, 6'b00_1100, 1, 32'h500);
    wait_empty("post_abort_drained");

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_rdata_router.md
AXI_RDATA_ROUTER -- requirements
Module: axi_rdata_router

Interface
REQ-001 Parameter NUM_M, default 3, number of masters (1..4).
REQ-002 Parameter NUM_S, default 4, number of real slaves (1..8).
REQ-003 Parameter ID_BITS, default 4, master-side ID width; MB=$clog2(NUM_M), SID=ID_BITS+MB slave-side ID width; upper MB bits of slave ID select the master.
REQ-004 Parameter DATA_BITS, default 32.
REQ-005 clk  in  1  clock; rst  in  1  reset, asynchronous, active-low.
REQ-006 s_rid  in  NUM_S*SID; s_rdata  in  NUM_S*DATA_BITS; s_rresp  in  NUM_S*2; s_rlast, s_rvalid  in  NUM_S; s_rready  out  NUM_S  (per-slave R channels, flattened).
REQ-007 m_rid  out  NUM_M*ID_BITS; m_rdata  out  NUM_M*DATA_BITS; m_rresp  out  NUM_M*2; m_rlast, m_rvalid  out  NUM_M; m_rready  in  NUM_M.
REQ-008 err_req_valid  in  1; err_req_ready  out  1; err_req_master  in  MB; err_req_id  in  ID_BITS; err_req_len  in  8  (decode-error burst request from address decoder).
REQ-009 finish  out  NUM_S+1  one-cycle pulse on last-beat handshake per source (bit NUM_S = default slave); route_err  out  1  sticky flag.

Function
REQ-010 Sources = NUM_S slaves plus default slave (index NUM_S); default slave valid = err_pending.
REQ-011 err_req accepted when err_req_valid & err_req_ready; err_req_ready = ~err_pending; accepted fields registered, beat counter loaded with err_req_len, err_pending set next cycle.
REQ-012 Default slave beats: rdata 0, rresp 2'b11 (DECERR), rid = stored id, rlast when counter==0; counter decrements per handshake; err_pending clears on last-beat handshake; burst of len+1 beats.
REQ-013 FSM states IDLE, LOCK. IDLE: round-robin grant among valid sources starting at rr_ptr, combinational, beat routed same cycle (zero latency).
REQ-014 IDLE, granted beat handshaken with rlast -> stay IDLE, rr_ptr = grant+1 mod (NUM_S+1); handshaken without rlast or not handshaken -> LOCK with grant registered.
REQ-015 LOCK: grant fixed, no arbitration; last-beat handshake -> IDLE, rr_ptr = grant+1; other sources' s_rready held 0.
REQ-016 Routing: target master = granted source's ID upper bits; only that master sees m_rvalid=s_rvalid, payload, m_rid = lower ID_BITS; s_rready(grant) = m_rready(target) & s_rvalid(grant); all non-targeted outputs 0.
REQ-017 Target index >= NUM_M: beat sunk (s_rready=1), no master valid, route_err set until reset; burst ends normally on rlast.
REQ-018 finish(grant) pulses the cycle of last-beat handshake only.
REQ-019 Payload from a slave without grant never reaches any master; a master sees at most one valid beat per cycle.
REQ-020 Simultaneous err_req accept and default-slave last beat impossible (ready low while pending); new request accepted the cycle after clear.

Reset
REQ-021 On rst low: state IDLE, rr_ptr 0, grant 0, err_pending 0, counter 0, route_err 0; all m_rvalid, s_rready, finish, err_req_ready outputs 0 while reset asserted, err_req_ready 1 after release.
REQ-022 Reset mid-burst aborts the burst without completing it; no further beats routed from it.

Structure
REQ-023 Shared package axi_pkg holds RESP_OKAY/RESP_DECERR constants and the router state enum.
REQ-024 One sub-module axi_rr_arbiter (parametrised request width, pointer input, one-hot/index grant output).

Verification
REQ-025 Slave1 single beat ID={01,0x3}, m_rready1=1 -> same cycle m_rvalid1=1, m_rid1=0x3, finish[1] pulse, state stays IDLE.
REQ-026 Slaves 0 and 2 valid together, rr_ptr=0, 4-beat bursts -> slave0 burst fully delivered, then slave2; no interleave.
REQ-027 err_req master=0, id=0x5, len=3 -> 4 beats to master0, rresp=2'b11, rlast on 4th, err_req_ready low until after 4th.
REQ-028 Master ready toggled 1/0 during locked burst -> data held, no beat lost or duplicated, s_rready tracks m_rready.
REQ-029 Slave ID upper bits = 3 with NUM_M=3 -> beats sunk, no m_rvalid, route_err=1.
REQ-030 rst asserted at beat 2 of 4 -> all outputs 0, IDLE after release, next request routed correctly.
